// File: rtl/pwr_seq_pkg.sv
// Shared types for the isolation/power sequencer: state encoding used by
// the controller, the PMU model and bench scoreboards.
package pwr_seq_pkg;

  typedef enum logic [2:0] {
    ON      = 3'd0,
    ISO     = 3'd1,
    SAVE    = 3'd2,
    PSW_OFF = 3'd3,
    OFF     = 3'd4,
    PSW_ON  = 3'd5,
    RESTORE = 3'd6,
    UNISO   = 3'd7
  } pwr_state_e;

endpackage

// File: rtl/iso_pwr_seq_ctrl.sv
// Power-sequencing controller for one switchable domain.
// Down: isolate -> save retention -> switch off. Up: switch on -> restore -> de-isolate.
//
// state   | meaning
// --------+------------------------------------------------------------
// ON      | domain powered, outputs unclamped
// ISO     | clamps asserted, waiting ISO_SETUP cycles for settle
// SAVE    | one-cycle retention save pulse; sequence committed
// PSW_OFF | switch released, waiting for power-good to drop
// OFF     | domain off and isolated, sleep_ack high
// PSW_ON  | switch enabled, waiting for power-good
// RESTORE | one-cycle retention restore pulse (suppressed after a failed power-down)
// UNISO   | clamps held ISO_HOLD cycles before release
module iso_pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int ISO_SETUP   = 2,
  parameter int ISO_HOLD    = 2,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sleep_req,
  output logic sleep_ack,
  output logic iso_en,
  output logic save,
  output logic restore,
  output logic pwr_sw_en,
  input  logic pwr_sw_ack,
  output logic timeout_err
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(ISO_HOLD - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMR_MAX    = '1;

  pwr_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             skip_restore_q, skip_restore_d;
  logic             err_d;
  logic             iso_en_d, save_d, restore_d, pwr_sw_en_d, sleep_ack_d;

  // Next-state, timer and registered-output decode.
  always_comb begin
    state_d        = state_q;
    skip_restore_d = skip_restore_q;
    err_d          = timeout_err;

    case (state_q)
      ON: begin
        if (sleep_req) state_d = ISO;
      end
      ISO: begin
        if (!sleep_req)                 state_d = UNISO;
        else if (timer_q >= SETUP_LAST) state_d = SAVE;
      end
      SAVE: begin
        state_d        = PSW_OFF;
        skip_restore_d = 1'b0;
      end
      PSW_OFF: begin
        if (!pwr_sw_ack) begin
          state_d = OFF;
        end else if (timer_q >= ACK_LAST) begin
          // Switch never let go: the domain kept its state, so come back
          // up without restoring over it.
          state_d        = PSW_ON;
          err_d          = 1'b1;
          skip_restore_d = 1'b1;
        end
      end
      OFF: begin
        if (!sleep_req) state_d = PSW_ON;
      end
      PSW_ON: begin
        if (pwr_sw_ack) begin
          state_d = RESTORE;
        end else if (timer_q >= ACK_LAST) begin
          state_d = OFF;
          err_d   = 1'b1;
        end
      end
      RESTORE: begin
        state_d = UNISO;
      end
      UNISO: begin
        if (timer_q >= HOLD_LAST) begin
          state_d        = ON;
          skip_restore_d = 1'b0;
        end
      end
      default: state_d = ON;
    endcase

    if (state_d != state_q)    timer_d = '0;
    else if (timer_q == TMR_MAX) timer_d = timer_q;
    else                       timer_d = timer_q + 1'b1;

    iso_en_d    = (state_d != ON);
    pwr_sw_en_d = (state_d != PSW_OFF) && (state_d != OFF);
    save_d      = (state_d == SAVE);
    restore_d   = (state_d == RESTORE) && !skip_restore_d;
    sleep_ack_d = (state_d == OFF);
  end

  // State, timer and output registers; reset leaves the domain powered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ON;
      timer_q        <= '0;
      skip_restore_q <= 1'b0;
      timeout_err    <= 1'b0;
      iso_en         <= 1'b0;
      pwr_sw_en      <= 1'b1;
      save           <= 1'b0;
      restore        <= 1'b0;
      sleep_ack      <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      skip_restore_q <= skip_restore_d;
      timeout_err    <= err_d;
      iso_en         <= iso_en_d;
      pwr_sw_en      <= pwr_sw_en_d;
      save           <= save_d;
      restore        <= restore_d;
      sleep_ack      <= sleep_ack_d;
    end
  end

endmodule

// File: tb/tb_iso_pwr_seq_ctrl.sv
// Directed bench for iso_pwr_seq_ctrl with a 3-cycle switch-chain model.
module tb_iso_pwr_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sleep_req = 1'b0;
  logic sleep_ack, iso_en, save, restore, pwr_sw_en, pwr_sw_ack, timeout_err;

  // 0: ack follows pwr_sw_en after 3 cycles, 1: stuck high, 2: stuck low
  int ack_mode = 0;
  logic [2:0] sw_dly = 3'b111;

  int total    = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  iso_pwr_seq_ctrl #(
    .ISO_SETUP  (2),
    .ISO_HOLD   (2),
    .ACK_TIMEOUT(64),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sleep_req  (sleep_req),
    .sleep_ack  (sleep_ack),
    .iso_en     (iso_en),
    .save       (save),
    .restore    (restore),
    .pwr_sw_en  (pwr_sw_en),
    .pwr_sw_ack (pwr_sw_ack),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sw_dly <= {sw_dly[1:0], pwr_sw_en};

  always_comb begin
    case (ack_mode)
      1:       pwr_sw_ack = 1'b1;
      2:       pwr_sw_ack = 1'b0;
      default: pwr_sw_ack = sw_dly[2];
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_iso"},     32'(iso_en),      0);
    chk({tag, "_psw"},     32'(pwr_sw_en),   1);
    chk({tag, "_save"},    32'(save),        0);
    chk({tag, "_restore"}, 32'(restore),     0);
    chk({tag, "_ack"},     32'(sleep_ack),   0);
    chk({tag, "_err"},     32'(timeout_err), 0);
  endtask

  initial begin
    logic bad_iso, bad_save, bad_psw, bad_restore, bad_ack;
    int n;

    // Reset
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) tick();
    chk_reset_outputs("idle_on");

    // Power-down: iso@1, save@3, pwr_sw_en=0@4, sleep_ack@8
    sleep_req = 1'b1;
    bad_iso = 0; bad_save = 0; bad_psw = 0; bad_ack = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (iso_en !== 1'b1)             bad_iso  = 1;
      if (save !== (k == 3))           bad_save = 1;
      if (pwr_sw_en !== (k < 4))       bad_psw  = 1;
      if (sleep_ack !== (k >= 8))      bad_ack  = 1;
    end
    chk("down_iso_held",   32'(bad_iso),  0);
    chk("down_save_at3",   32'(bad_save), 0);
    chk("down_psw_off_at4",32'(bad_psw),  0);
    chk("down_ack_at8",    32'(bad_ack),  0);

    // Power-up: pwr_sw_en@1, sleep_ack=0@1, restore@5, iso_en=0@8
    sleep_req = 1'b0;
    bad_iso = 0; bad_restore = 0; bad_psw = 0; bad_ack = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (iso_en !== (k < 8))          bad_iso     = 1;
      if (restore !== (k == 5))        bad_restore = 1;
      if (pwr_sw_en !== 1'b1)          bad_psw     = 1;
      if (sleep_ack !== 1'b0)          bad_ack     = 1;
    end
    chk("up_iso_release_at8", 32'(bad_iso),     0);
    chk("up_restore_at5",     32'(bad_restore), 0);
    chk("up_psw_on_at1",      32'(bad_psw),     0);
    chk("up_ack_low_at1",     32'(bad_ack),     0);
    chk("up_err_clear",       32'(timeout_err), 0);

    // One-cycle sleep_req pulse: abort from ISO without save
    repeat (3) tick();
    sleep_req = 1'b1;
    tick();
    chk("abort_iso_at1", 32'(iso_en), 1);
    sleep_req = 1'b0;
    bad_iso = 0; bad_save = 0; bad_psw = 0;
    for (int k = 2; k <= 6; k++) begin
      tick();
      if (iso_en !== (k < 4))          bad_iso  = 1;
      if (save !== 1'b0)               bad_save = 1;
      if (pwr_sw_en !== 1'b1)          bad_psw  = 1;
    end
    chk("abort_iso_release_at4", 32'(bad_iso),  0);
    chk("abort_no_save",         32'(bad_save), 0);
    chk("abort_psw_steady",      32'(bad_psw),  0);

    // pwr_sw_ack stuck high in PSW_OFF -> timeout 64 cycles after entry
    sleep_req = 1'b1;
    repeat (4) tick();
    chk("psw_off_entered", 32'(pwr_sw_en), 0);
    ack_mode = 1;
    bad_restore = 0; bad_ack = 0;
    for (int k = 5; k <= 67; k++) begin
      tick();
      if (restore !== 1'b0)   bad_restore = 1;
      if (sleep_ack !== 1'b0) bad_ack     = 1;
    end
    chk("psw_off_wait_psw", 32'(pwr_sw_en),   0);
    chk("psw_off_wait_err", 32'(timeout_err), 0);
    tick();
    chk("psw_off_to_psw",   32'(pwr_sw_en),   1);
    chk("psw_off_to_err",   32'(timeout_err), 1);
    sleep_req = 1'b0;
    for (int k = 69; k <= 72; k++) begin
      tick();
      if (restore !== 1'b0)   bad_restore = 1;
      if (sleep_ack !== 1'b0) bad_ack     = 1;
    end
    chk("psw_off_to_no_restore", 32'(bad_restore), 0);
    chk("psw_off_to_never_off",  32'(bad_ack),     0);
    chk("psw_off_to_ends_on",    32'(iso_en),      0);
    tick();
    chk("psw_off_to_err_sticky", 32'(timeout_err), 1);
    ack_mode = 0;

    // Reset while in PSW_OFF
    repeat (3) tick();
    sleep_req = 1'b1;
    repeat (4) tick();
    chk("rst_a_in_psw_off", 32'(pwr_sw_en), 0);
    rst = 1'b1;
    tick();
    chk_reset_outputs("rst_a");
    rst = 1'b0;
    sleep_req = 1'b0;
    tick();
    chk("rst_a_stays_on", 32'(iso_en), 0);
    repeat (5) tick();

    // pwr_sw_ack stuck low in PSW_ON -> back to OFF, isolated
    sleep_req = 1'b1;
    repeat (8) tick();
    chk("off_reached", 32'(sleep_ack), 1);
    ack_mode  = 2;
    sleep_req = 1'b0;
    tick();
    chk("psw_on_entered", 32'(pwr_sw_en), 1);
    sleep_req = 1'b1;
    bad_restore = 0; bad_iso = 0;
    for (int k = 2; k <= 64; k++) begin
      tick();
      if (restore !== 1'b0) bad_restore = 1;
      if (iso_en !== 1'b1)  bad_iso     = 1;
    end
    chk("psw_on_wait_err", 32'(timeout_err), 0);
    chk("psw_on_wait_ack", 32'(sleep_ack),   0);
    tick();
    chk("psw_on_to_err", 32'(timeout_err), 1);
    chk("psw_on_to_ack", 32'(sleep_ack),   1);
    chk("psw_on_to_iso", 32'(iso_en),      1);
    chk("psw_on_to_psw", 32'(pwr_sw_en),   0);
    chk("psw_on_to_no_restore", 32'(bad_restore), 0);
    chk("psw_on_to_iso_held",   32'(bad_iso),     0);
    tick();
    chk("psw_on_to_holds_off", 32'(sleep_ack), 1);

    // Retry power-up after PSW_ON timeout; error stays set
    ack_mode  = 0;
    sleep_req = 1'b0;
    n = 0;
    while (iso_en !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    chk("retry_completes",  32'(n < 40),       1);
    chk("retry_err_sticky", 32'(timeout_err),  1);
    chk("retry_psw_on",     32'(pwr_sw_en),    1);
    chk("retry_ack_low",    32'(sleep_ack),    0);

    // Reset while in UNISO (also clears the sticky error)
    repeat (3) tick();
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    tick();
    chk("rst_b_in_uniso", 32'(iso_en), 1);
    rst = 1'b1;
    tick();
    chk_reset_outputs("rst_b");
    rst = 1'b0;
    tick();
    chk("rst_b_stays_on", 32'(iso_en), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
